// File: rtl/gpu_core_pkg.sv
// Shared opcode encoding, field positions and multiplier state type for the
// per-pixel GPU core.
package gpu_core_pkg;

  localparam int OPCODE_W = 14;

  localparam int OP_MSB  = 13;
  localparam int OP_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LDX  = 4'd2;
  localparam logic [3:0] OP_LDY  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_LD   = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_CLT  = 4'd13;
  localparam logic [3:0] OP_SADD = 4'd14;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/core_mul.sv
// Sequential shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per product, low WIDTH bits of the result only.
module core_mul
  import gpu_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] part;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MUL_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state <= MUL_RUN;
            cnt   <= CNT_W'(WIDTH);
          end
        end
        MUL_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MUL_IDLE;
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == MUL_IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      part   <= '0;
    end else if (state == MUL_RUN) begin
      part   <= p;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // p is the partial product after the current step, so on the last step it
  // is the finished result and the core can write it back on that same edge.
  assign p    = part + (mplier[0] ? mcand : '0);
  assign busy = (state == MUL_RUN);
  assign done = busy && (cnt == CNT_W'(1));

endmodule

// File: rtl/gpu_core_alu.sv
// Per-pixel GPU core: opcode decode, small register file, accumulator update
// and the busy handshake around the multi-cycle multiplier.
module gpu_core_alu
  import gpu_core_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                execute,
  input  logic [WIDTH-1:0]    x,
  input  logic [WIDTH-1:0]    y,
  output logic                busy,
  output logic [WIDTH-1:0]    accu,
  output logic                accu_lsb
);

  logic [3:0]       op;
  logic [1:0]       rs;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] accu_nxt;
  logic [WIDTH-1:0] mul_p;
  logic             rs_ok;
  logic             accept;
  logic             mul_done;
  logic [WIDTH-1:0] regs [4];

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] shr_logic(input logic [WIDTH-1:0] a,
                                                 input logic [3:0]       sh);
    return (int'(sh) >= WIDTH) ? '0 : (a >> sh);
  endfunction

  assign op     = opcode[OP_MSB:OP_LSB];
  assign rs     = opcode[RS_MSB:RS_LSB];
  assign shamt  = opcode[IMM_LSB+3:IMM_LSB];
  assign imm    = WIDTH'(opcode[IMM_MSB:IMM_LSB]);
  assign rs_ok  = int'(rs) < NUM_REGS;
  assign rd_val = rs_ok ? regs[rs] : '0;
  assign accept = execute && !busy;

  always_comb begin
    accu_nxt = accu;
    case (op)
      OP_NOP:  accu_nxt = accu;
      OP_LDI:  accu_nxt = imm;
      OP_LDX:  accu_nxt = x;
      OP_LDY:  accu_nxt = y;
      OP_ADDI: accu_nxt = accu + imm;
      OP_ADD:  accu_nxt = accu + rd_val;
      OP_SUB:  accu_nxt = accu - rd_val;
      OP_AND:  accu_nxt = accu & rd_val;
      OP_XOR:  accu_nxt = accu ^ rd_val;
      OP_SHR:  accu_nxt = shr_logic(accu, shamt);
      OP_LD:   accu_nxt = rd_val;
      OP_CLT:  accu_nxt = WIDTH'(accu < rd_val);
      OP_SADD: accu_nxt = sat_add(accu, imm);
      default: accu_nxt = accu;
    endcase
  end

  core_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && (op == OP_MUL)),
    .a     (accu),
    .b     (rd_val),
    .busy  (busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Accept stage: single-cycle results and multiplier writeback share one edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accu <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (mul_done)    accu <= mul_p;
      else if (accept) accu <= accu_nxt;
      if (accept && op == OP_ST && rs_ok) regs[rs] <= accu;
    end
  end

  assign accu_lsb = accu[0];

endmodule

// File: tb/tb_gpu_core_alu.sv
// Scoreboard bench for gpu_core_alu at WIDTH=8/NUM_REGS=4 and WIDTH=4/NUM_REGS=2.
module tb_gpu_core_alu;

  typedef struct {
    int cyc;
    int dut;
    int acc;
    int busy;
    int op;
  } exp_t;

  logic        clk;
  logic        rst8_n, rst4_n;
  logic        exec8, exec4;
  logic [13:0] opc8, opc4;
  logic [7:0]  x8, y8;
  logic [3:0]  x4, y4;
  logic        busy8, busy4, lsb8, lsb4;
  logic [7:0]  accu8;
  logic [3:0]  accu4;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  int W_OF  [2] = '{8, 4};
  int NR_OF [2] = '{4, 2};
  int m_acc [2];
  int m_r   [2][4];
  int tbx   [2];
  int tby   [2];

  assign x8 = tbx[0][7:0];
  assign y8 = tby[0][7:0];
  assign x4 = tbx[1][3:0];
  assign y4 = tby[1][3:0];

  gpu_core_alu #(.WIDTH(8), .NUM_REGS(4)) dut8 (
    .clk(clk), .rst_n(rst8_n), .opcode(opc8), .execute(exec8),
    .x(x8), .y(y8), .busy(busy8), .accu(accu8), .accu_lsb(lsb8)
  );

  gpu_core_alu #(.WIDTH(4), .NUM_REGS(2)) dut4 (
    .clk(clk), .rst_n(rst4_n), .opcode(opc4), .execute(exec4),
    .x(x4), .y(y4), .busy(busy4), .accu(accu4), .accu_lsb(lsb4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  // Monitor: compare every expectation due at the current cycle.
  always @(negedge clk) begin
    exp_t e;
    int aa, bb, ll;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      aa = (e.dut == 0) ? int'(accu8) : int'(accu4);
      bb = (e.dut == 0) ? int'(busy8) : int'(busy4);
      ll = (e.dut == 0) ? int'(lsb8)  : int'(lsb4);
      total++;
      if (aa != e.acc || bb != e.busy || ll != (e.acc & 1)) begin
        bad++;
        $display("FAIL op%0d dut%0d cyc%0d: accu=%0d busy=%0d lsb=%0d, expected accu=%0d busy=%0d lsb=%0d",
                 e.op, e.dut, cyc, aa, bb, ll, e.acc, e.busy, e.acc & 1);
      end
    end
  end

  function automatic void push(input int d, input int c, input int a, input int b, input int op);
    exp_t e;
    e.cyc = c; e.dut = d; e.acc = a; e.busy = b; e.op = op;
    sb.push_back(e);
  endfunction

  // Reference model: applies one accepted instruction with plain integer arithmetic.
  function automatic void model(input int d, input int op, input int rs, input int imm);
    int m, iv, rv, a, sh;
    m  = 1 << W_OF[d];
    iv = imm % m;
    a  = m_acc[d];
    rv = (rs < NR_OF[d]) ? m_r[d][rs] : 0;
    case (op)
      1:  a = iv;
      2:  a = tbx[d] % m;
      3:  a = tby[d] % m;
      4:  a = (a + iv) % m;
      5:  a = (a + rv) % m;
      6:  a = (a - rv + m) % m;
      7:  a = a & rv;
      8:  a = a ^ rv;
      9:  begin sh = imm % 16; a = (sh >= W_OF[d]) ? 0 : a / (1 << sh); end
      10: if (rs < NR_OF[d]) m_r[d][rs] = a;
      11: a = rv;
      12: a = (a * rv) % m;
      13: a = (a < rv) ? 1 : 0;
      14: a = (a + iv > m - 1) ? m - 1 : a + iv;
      default: ;
    endcase
    m_acc[d] = a;
  endfunction

  function automatic void model_reset(input int d);
    m_acc[d] = 0;
    for (int i = 0; i < 4; i++) m_r[d][i] = 0;
  endfunction

  task automatic set_in(input int d, input logic ex, input int op, input int rs, input int imm);
    logic [13:0] w;
    w = 14'(((op & 15) << 10) | ((rs & 3) << 8) | (imm & 255));
    if (d == 0) begin exec8 = ex; opc8 = w; end
    else        begin exec4 = ex; opc4 = w; end
  endtask

  task automatic set_rst(input int d, input logic v);
    if (d == 0) rst8_n = v;
    else        rst4_n = v;
  endtask

  task automatic do_reset(input int d);
    int nc;
    nc = cyc;
    set_rst(d, 1'b0);
    for (int k = 0; k < 2; k++) begin
      set_in(d, 1'b1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 255));
      push(d, nc + 1 + k, 0, 0, -1);
      @(negedge clk);
    end
    set_rst(d, 1'b1);
    set_in(d, 1'b0, 0, 0, 0);
    model_reset(d);
  endtask

  // strobe_at in 1..W re-asserts execute with a random opcode while busy.
  task automatic issue(input int d, input int op, input int rs, input int imm, input int strobe_at);
    int nc, old, w;
    nc  = cyc;
    w   = W_OF[d];
    old = m_acc[d];
    set_in(d, 1'b1, op, rs, imm);
    model(d, op, rs, imm);
    if (op != 12) begin
      push(d, nc + 1, m_acc[d], 0, op);
      @(negedge clk);
      set_in(d, 1'b0, 0, 0, 0);
    end else begin
      for (int k = 0; k < w; k++) push(d, nc + 1 + k, old, 1, op);
      push(d, nc + 1 + w, m_acc[d], 0, op);
      @(negedge clk);
      set_in(d, 1'b0, 0, 0, 0);
      for (int k = 1; k <= w; k++) begin
        if (k == strobe_at) set_in(d, 1'b1, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 255));
        @(negedge clk);
        set_in(d, 1'b0, 0, 0, 0);
      end
    end
  endtask

  task automatic mul_abort(input int d, input int rs);
    int nc, old, w;
    nc  = cyc;
    w   = W_OF[d];
    old = m_acc[d];
    set_in(d, 1'b1, 12, rs, 0);
    for (int k = 1; k <= 3; k++) push(d, nc + k, old, 1, 12);
    push(d, nc + 4, 0, 0, 12);
    @(negedge clk);
    set_in(d, 1'b0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    set_rst(d, 1'b0);
    @(negedge clk);
    set_rst(d, 1'b1);
    model_reset(d);
    for (int k = 1; k <= w + 1; k++) begin
      push(d, nc + 4 + k, 0, 0, 12);
      @(negedge clk);
    end
  endtask

  task automatic random_ops(input int d, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      tbx[d] = $urandom_range(0, 255);
      tby[d] = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      issue(d, op, $urandom_range(0, 3), $urandom_range(0, 255),
            (op == 12) ? $urandom_range(0, W_OF[d]) : 0);
    end
  endtask

  initial begin
    rst8_n = 1'b0; rst4_n = 1'b0;
    exec8 = 1'b0; exec4 = 1'b0;
    opc8 = '0; opc4 = '0;
    tbx = '{0, 0}; tby = '{0, 0};
    model_reset(0); model_reset(1);
    @(negedge clk);
    @(negedge clk);

    // WIDTH=8: reset with random strobes, then registers read back zero
    do_reset(0);
    for (int r = 0; r < 4; r++) issue(0, 11, r, 0, 0);
    // Arithmetic, wrap and saturation
    issue(0, 1, 0, 200, 0);
    issue(0, 10, 1, 0, 0);
    issue(0, 4, 0, 100, 0);
    issue(0, 6, 1, 0, 0);
    issue(0, 14, 0, 250, 0);
    issue(0, 14, 0, 1, 0);
    // Coordinates, logic and shift
    tbx[0] = 'h5A; tby[0] = 'h0F;
    issue(0, 2, 0, 0, 0);
    issue(0, 10, 2, 0, 0);
    issue(0, 3, 0, 0, 0);
    issue(0, 7, 2, 0, 0);
    issue(0, 8, 2, 0, 0);
    issue(0, 9, 0, 4, 0);
    issue(0, 9, 0, 9, 0);
    // Multiply timing and wrap
    issue(0, 1, 0, 13, 0);
    issue(0, 10, 0, 0, 0);
    issue(0, 1, 0, 11, 0);
    issue(0, 12, 0, 0, 0);
    issue(0, 1, 0, 20, 0);
    issue(0, 10, 0, 0, 0);
    issue(0, 12, 0, 0, 0);
    // Strobe while busy is ignored
    issue(0, 1, 0, 6, 0);
    issue(0, 10, 1, 0, 0);
    issue(0, 1, 0, 9, 0);
    issue(0, 12, 1, 0, 2);
    // Reset mid-multiply aborts it
    issue(0, 1, 0, 5, 0);
    issue(0, 10, 0, 0, 0);
    mul_abort(0, 0);
    random_ops(0, 300);

    // WIDTH=4, NUM_REGS=2
    do_reset(1);
    issue(1, 1, 0, 'hFF, 0);
    issue(1, 10, 3, 0, 0);
    issue(1, 11, 3, 0, 0);
    issue(1, 1, 0, 5, 0);
    issue(1, 10, 0, 0, 0);
    issue(1, 1, 0, 3, 0);
    issue(1, 12, 0, 0, 0);
    issue(1, 1, 0, 5, 0);
    issue(1, 12, 0, 0, 0);
    issue(1, 1, 0, 3, 0);
    issue(1, 13, 0, 0, 0);
    random_ops(1, 200);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
